// File: rtl/image_filter_uart_frame_ctrl_if.sv
// Bundles the UART RX/TX byte streams and the filter frame/result handshakes
// of the frame controller into one port group.
interface image_filter_uart_frame_ctrl_if #(
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT         = 392
);
  logic                     s_byte_valid;
  logic [BITS_PER_WORD-1:0] s_byte_data;
  logic                     m_frame_valid;
  logic                     m_frame_ready;
  logic [W_OUT-1:0]         m_frame_data;
  logic [3:0]               m_frame_mode;
  logic                     s_res_valid;
  logic                     s_res_ready;
  logic [W_OUT-1:0]         s_res_data;
  logic                     m_byte_valid;
  logic                     m_byte_ready;
  logic [BITS_PER_WORD-1:0] m_byte_data;

  modport master (
    input  s_byte_valid, s_byte_data, m_frame_ready, s_res_valid, s_res_data, m_byte_ready,
    output m_frame_valid, m_frame_data, m_frame_mode, s_res_ready, m_byte_valid, m_byte_data
  );

  modport slave (
    output s_byte_valid, s_byte_data, m_frame_ready, s_res_valid, s_res_data, m_byte_ready,
    input  m_frame_valid, m_frame_data, m_frame_mode, s_res_ready, m_byte_valid, m_byte_data
  );
endinterface

// File: rtl/image_filter_uart_frame_ctrl.sv
// Frame controller: header parse, frame assembly, filter handshake, echo + result TX.
// Optional RX_TIMEOUT_EN adds an inter-byte timeout that aborts a stalled RECV.
module image_filter_uart_frame_ctrl #(
  parameter int         R_I            = 7,
  parameter int         C_I            = 7,
  parameter int         W_I            = 8,
  parameter int         BITS_PER_WORD  = 8,
  parameter int         NUM_MODES      = 4,
  parameter logic [3:0] SYNC           = 4'hA,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  image_filter_uart_frame_ctrl_if.master bus,
  output logic                          busy,
  output logic                          err_bad_cmd,
  output logic                          err_overrun
);
  localparam int W_OUT     = R_I * C_I * W_I;
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [4:0] MODES5 = 5'(NUM_MODES);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RECV       = 3'd1;
  localparam logic [2:0] SEND_FRAME = 3'd2;
  localparam logic [2:0] WAIT_RES   = 3'd3;
  localparam logic [2:0] TX_HDR     = 3'd4;
  localparam logic [2:0] TX_DATA    = 3'd5;

  logic [2:0]                                 state;
  logic [CNT_W-1:0]                           cnt;
  logic [IDX_W-1:0]                           idx;
  logic [BITS_PER_WORD-1:0]                   hdr_q;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]    frame_q;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]    res_q;
  logic                                       hdr_ok;
  logic                                       last_word;
  logic                                       rx_timeout;

  assign idx       = cnt[IDX_W-1:0];
  assign last_word = (cnt == CNT_W'(NUM_WORDS - 1));
  assign hdr_ok    = (bus.s_byte_data[7:4] == SYNC) && ({1'b0, bus.s_byte_data[3:0]} < MODES5);

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Idle cycles since the last RX byte; only meaningful while receiving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   to_cnt <= '0;
    else if (state != RECV || bus.s_byte_valid) to_cnt <= '0;
    else                                       to_cnt <= to_cnt + 1'b1;
  end

  assign rx_timeout = (state == RECV) && !bus.s_byte_valid &&
                      (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign rx_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hdr_q       <= '0;
      frame_q     <= '0;
      res_q       <= '0;
      err_bad_cmd <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_bad_cmd <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        IDLE: if (bus.s_byte_valid) begin
          if (hdr_ok) begin
            hdr_q <= bus.s_byte_data;
            cnt   <= '0;
            state <= RECV;
          end else begin
            err_bad_cmd <= 1'b1;
          end
        end
        RECV: begin
          if (bus.s_byte_valid) begin
            frame_q[idx] <= bus.s_byte_data;
            if (last_word) begin
              cnt   <= '0;
              state <= SEND_FRAME;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (rx_timeout) begin
            frame_q     <= '0;
            cnt         <= '0;
            err_bad_cmd <= 1'b1;
            state       <= IDLE;
          end
        end
        SEND_FRAME: if (bus.m_frame_ready) state <= WAIT_RES;
        WAIT_RES: if (bus.s_res_valid) begin
          res_q <= bus.s_res_data;
          state <= TX_HDR;
        end
        TX_HDR: if (bus.m_byte_ready) begin
          cnt   <= '0;
          state <= TX_DATA;
        end
        TX_DATA: if (bus.m_byte_ready) begin
          if (last_word) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // RX has no back-pressure: anything outside IDLE/RECV is lost.
      if (bus.s_byte_valid && state != IDLE && state != RECV) err_overrun <= 1'b1;
    end
  end

  assign bus.m_frame_valid = (state == SEND_FRAME);
  assign bus.m_frame_data  = frame_q;
  assign bus.m_frame_mode  = hdr_q[3:0];
  assign bus.s_res_ready   = (state == WAIT_RES);
  assign bus.m_byte_valid  = (state == TX_HDR) || (state == TX_DATA);
  assign bus.m_byte_data   = (state == TX_HDR)  ? hdr_q :
                             (state == TX_DATA) ? res_q[idx] : '0;
  assign busy              = (state != IDLE);
endmodule

// File: tb/tb_image_filter_uart_frame_ctrl.sv
// Directed bench for the frame controller: reset, full frames, bad headers,
// overrun drops, mid-frame reset and (when enabled) RX timeout.
module tb_image_filter_uart_frame_ctrl;
  localparam int R_I = 7, C_I = 7, W_I = 8, BPW = 8, NUM_MODES = 4;
  localparam int W_OUT = R_I * C_I * W_I;
  localparam int NW    = W_OUT / BPW;
`ifdef RX_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1_000_000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy, err_bad_cmd, err_overrun;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  image_filter_uart_frame_ctrl_if #(.BITS_PER_WORD(BPW), .W_OUT(W_OUT)) bus ();

  image_filter_uart_frame_ctrl #(
    .R_I(R_I), .C_I(C_I), .W_I(W_I), .BITS_PER_WORD(BPW),
    .NUM_MODES(NUM_MODES), .SYNC(4'hA), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .err_bad_cmd(err_bad_cmd), .err_overrun(err_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.s_byte_valid = 1'b1;
    bus.s_byte_data  = b;
    tick();
    bus.s_byte_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [7:0] flags;
    flags = {2'b0, bus.m_frame_valid, bus.s_res_ready, bus.m_byte_valid, busy, err_bad_cmd, err_overrun};
    n_total++;
    if (flags !== 8'h00) $display("FAIL %s_flags: got %h want 00", tag, flags);
    else n_pass++;
    n_total++;
    if (bus.m_frame_data !== '0 || bus.m_frame_mode !== 4'h0 || bus.m_byte_data !== 8'h00)
      $display("FAIL %s_data: got mode %h byte %h frame_lsb %h want zeros",
               tag, bus.m_frame_mode, bus.m_byte_data, bus.m_frame_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");
  endtask

  // Full frame round trip; tb plays the filter (result byte k = C3 ^ (seed + 2k)).
  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] seed, input bit inject);
    logic [NW-1:0][7:0] fexp, rexp, got;
    logic [7:0] got_hdr, prev;
    int  nrx, c;
    bit  stalled, inj_pending, inj_done;

    send_byte(hdr);
    n_total++;
    if (busy !== 1'b1) $display("FAIL hdr_busy: got %b want 1", busy); else n_pass++;
    for (int k = 0; k < NW; k++) begin
      fexp[k] = seed + 8'(k);
      rexp[k] = 8'hC3 ^ (seed + 8'(2 * k));
      send_byte(fexp[k]);
    end
    n_total++;
    if (bus.m_frame_valid !== 1'b1) $display("FAIL frame_valid: got %b want 1", bus.m_frame_valid);
    else n_pass++;
    n_total++;
    if (bus.m_frame_mode !== hdr[3:0]) $display("FAIL frame_mode: got %h want %h", bus.m_frame_mode, hdr[3:0]);
    else n_pass++;
    n_total++;
    if (bus.m_frame_data[7:0] !== seed || bus.m_frame_data[391:384] !== seed + 8'd48)
      $display("FAIL frame_ends: got %h/%h want %h/%h", bus.m_frame_data[7:0],
               bus.m_frame_data[391:384], seed, seed + 8'd48);
    else n_pass++;
    n_total++;
    if (bus.m_frame_data !== fexp) $display("FAIL frame_data: got %h want %h", bus.m_frame_data, fexp);
    else n_pass++;

    repeat (5) tick();
    n_total++;
    if (bus.m_frame_valid !== 1'b1 || bus.m_frame_data !== fexp || bus.m_frame_mode !== hdr[3:0])
      $display("FAIL frame_hold: got valid %b mode %h want 1 %h", bus.m_frame_valid, bus.m_frame_mode, hdr[3:0]);
    else n_pass++;
    bus.m_frame_ready = 1'b1;
    tick();
    bus.m_frame_ready = 1'b0;
    n_total++;
    if (bus.m_frame_valid !== 1'b0 || bus.s_res_ready !== 1'b1)
      $display("FAIL frame_hs: got valid %b res_ready %b want 0 1", bus.m_frame_valid, bus.s_res_ready);
    else n_pass++;

    if (inject) begin
      send_byte(8'hEE);
      n_total++;
      if (err_overrun !== 1'b1 || bus.s_res_ready !== 1'b1)
        $display("FAIL overrun_wait: got ovr %b res_ready %b want 1 1", err_overrun, bus.s_res_ready);
      else n_pass++;
      tick();
      n_total++;
      if (err_overrun !== 1'b0) $display("FAIL overrun_pulse: got %b want 0", err_overrun);
      else n_pass++;
    end

    repeat (4) tick();
    bus.s_res_valid = 1'b1;
    bus.s_res_data  = rexp;
    tick();
    bus.s_res_valid = 1'b0;
    n_total++;
    if (bus.s_res_ready !== 1'b0 || bus.m_byte_valid !== 1'b1)
      $display("FAIL res_hs: got res_ready %b byte_valid %b want 0 1", bus.s_res_ready, bus.m_byte_valid);
    else n_pass++;

    nrx = 0; c = 0; stalled = 0; inj_pending = 0; inj_done = 0; prev = '0; got_hdr = '0; got = '0;
    while (nrx < NW + 1 && c < 1000) begin
      if (inj_pending) begin
        bus.s_byte_valid = 1'b0;
        inj_pending = 0;
        n_total++;
        if (err_overrun !== 1'b1) $display("FAIL overrun_tx: got %b want 1", err_overrun);
        else n_pass++;
      end
      if (stalled) begin
        n_total++;
        if (bus.m_byte_valid !== 1'b1 || bus.m_byte_data !== prev)
          $display("FAIL tx_stall: got valid %b data %h want 1 %h", bus.m_byte_valid, bus.m_byte_data, prev);
        else n_pass++;
      end
      bus.m_byte_ready = (c % 3 == 0);
      if (inject && !inj_done && nrx == 10) begin
        bus.s_byte_valid = 1'b1;
        bus.s_byte_data  = 8'h77;
        inj_pending = 1;
        inj_done    = 1;
      end
      if (bus.m_byte_valid && bus.m_byte_ready) begin
        if (nrx == 0) got_hdr = bus.m_byte_data;
        else          got[nrx-1] = bus.m_byte_data;
        nrx++;
        stalled = 0;
      end else begin
        stalled = bus.m_byte_valid;
        prev    = bus.m_byte_data;
      end
      c++;
      tick();
    end
    bus.m_byte_ready = 1'b0;
    bus.s_byte_valid = 1'b0;
    n_total++;
    if (nrx != NW + 1) $display("FAIL tx_count: got %0d want %0d", nrx, NW + 1);
    else n_pass++;
    n_total++;
    if (got_hdr !== hdr) $display("FAIL tx_hdr: got %h want %h", got_hdr, hdr);
    else n_pass++;
    n_total++;
    if (got !== rexp) $display("FAIL tx_data: got %h want %h", got, rexp);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || bus.m_byte_valid !== 1'b0)
      $display("FAIL tx_done: got busy %b valid %b want 0 0", busy, bus.m_byte_valid);
    else n_pass++;
  endtask

  task automatic test_frame();
    run_frame(8'hA1, 8'h00, 1'b0);
  endtask

  task automatic test_overrun();
    run_frame(8'hA3, 8'h20, 1'b1);
  endtask

  task automatic test_bad_cmd();
    logic [7:0] bad [2];
    bad[0] = 8'h51;
    bad[1] = 8'hA7;
    for (int i = 0; i < 2; i++) begin
      send_byte(bad[i]);
      n_total++;
      if (err_bad_cmd !== 1'b1 || busy !== 1'b0)
        $display("FAIL bad_cmd_%h: got err %b busy %b want 1 0", bad[i], err_bad_cmd, busy);
      else n_pass++;
      tick();
      n_total++;
      if (err_bad_cmd !== 1'b0 || busy !== 1'b0)
        $display("FAIL bad_cmd_pulse_%h: got err %b busy %b want 0 0", bad[i], err_bad_cmd, busy);
      else n_pass++;
    end
    run_frame(8'hA0, 8'h80, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA3);
    for (int k = 0; k < 20; k++) send_byte(8'h11 + 8'(k));
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("mid_reset_rel");
    run_frame(8'hA2, 8'h40, 1'b0);
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_timeout();
    send_byte(8'hA1);
    for (int k = 0; k < 10; k++) send_byte(8'(k));
    repeat (99) tick();
    n_total++;
    if (err_bad_cmd !== 1'b0 || busy !== 1'b1)
      $display("FAIL timeout_early: got err %b busy %b want 0 1", err_bad_cmd, busy);
    else n_pass++;
    tick();
    n_total++;
    if (err_bad_cmd !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_fire: got err %b busy %b want 1 0", err_bad_cmd, busy);
    else n_pass++;
    tick();
    run_frame(8'hA3, 8'h10, 1'b0);
  endtask
`endif

  initial begin
    rst              = 1'b1;
    bus.s_byte_valid = 1'b0;
    bus.s_byte_data  = '0;
    bus.m_frame_ready = 1'b0;
    bus.s_res_valid  = 1'b0;
    bus.s_res_data   = '0;
    bus.m_byte_ready = 1'b0;
    test_reset();
    test_frame();
    test_bad_cmd();
    test_overrun();
    test_reset_mid();
`ifdef RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
